// File: rtl/maple_pkg.sv
// rtl/maple_pkg.sv - shared codes, FSM encoding and default counts for the Maple pattern decoder
package maple_pkg;

  typedef logic [2:0] code_t;

  localparam code_t CODE_NONE        = 3'd0;
  localparam code_t CODE_START_FRAME = 3'd1;
  localparam code_t CODE_START_CRC   = 3'd2;
  localparam code_t CODE_START_OCC   = 3'd3;
  localparam code_t CODE_START_RESET = 3'd4;
  localparam code_t CODE_END         = 3'd5;
  localparam code_t CODE_ERR_COUNT   = 3'd6;
  localparam code_t CODE_ERR_TIMEOUT = 3'd7;

  // One-hot so each counting state is a single flop test
  typedef enum logic [2:0] {
    ST_IDLE      = 3'b001,
    ST_START_CNT = 3'b010,
    ST_END_CNT   = 3'b100
  } state_t;

  localparam int DEF_CNT_W           = 8;
  localparam int DEF_START_FRAME_CNT = 4;
  localparam int DEF_START_CRC_CNT   = 6;
  localparam int DEF_START_OCC_CNT   = 8;
  localparam int DEF_START_RESET_CNT = 14;
  localparam int DEF_END_CNT         = 2;
  localparam int DEF_MIN_CNT         = 2;
  localparam int DEF_TIMEOUT_CYCLES  = 1024;

endpackage

// File: rtl/maple_stall_timer.sv
// rtl/maple_stall_timer.sv - idle-cycle timer that flags a stalled pattern
module maple_stall_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_timer;

  assign expired = run && (r_timer == LAST);

  // Count idle cycles while running; hold at the terminal value until cleared
  always_ff @(posedge clk) begin
    if (!reset || clear || !run) begin
      r_timer <= '0;
    end else if (!expired) begin
      r_timer <= r_timer + 1'b1;
    end
  end

endmodule

// File: rtl/maple_pattern_decoder.sv
// rtl/maple_pattern_decoder.sv - Maple bus start/end pattern decoder, stall timeout under MAPLE_PATTERN_TIMEOUT_EN
module maple_pattern_decoder
  import maple_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int START_FRAME_CNT = DEF_START_FRAME_CNT,
  parameter int START_CRC_CNT   = DEF_START_CRC_CNT,
  parameter int START_OCC_CNT   = DEF_START_OCC_CNT,
  parameter int START_RESET_CNT = DEF_START_RESET_CNT,
  parameter int END_CNT         = DEF_END_CNT,
  parameter int MIN_CNT         = DEF_MIN_CNT
`ifdef MAPLE_PATTERN_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdcka_posedge,
  input  logic             sdcka_negedge,
  input  logic             sdckb_posedge,
  input  logic             sdckb_negedge,
  input  logic             frame_active,
  output logic             pattern_valid,
  output logic [2:0]       pattern_code,
  output logic [CNT_W-1:0] pattern_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  code_t            r_code;
  logic [CNT_W-1:0] r_count;

  logic             w_cnt_sat;
  logic [3:0]       w_start_cls;
  logic [3:0]       w_end_cls;
  logic             w_timeout;

  // {report, code} for a closed start pattern
  function automatic logic [3:0] classify_start(input logic [CNT_W-1:0] c);
    int n;
    n = int'(c);
    if (c == CNT_MAX)           return {1'b1, CODE_ERR_COUNT};
    if (n < MIN_CNT)            return {1'b0, CODE_NONE};
    if (n == START_FRAME_CNT)   return {1'b1, CODE_START_FRAME};
    if (n == START_CRC_CNT)     return {1'b1, CODE_START_CRC};
    if (n == START_OCC_CNT)     return {1'b1, CODE_START_OCC};
    if (n == START_RESET_CNT)   return {1'b1, CODE_START_RESET};
    return {1'b1, CODE_ERR_COUNT};
  endfunction

  // {report, code} for a closed end pattern; 0 or 1 falls are just a data bit
  function automatic logic [3:0] classify_end(input logic [CNT_W-1:0] c);
    int n;
    n = int'(c);
    if (c == CNT_MAX)  return {1'b1, CODE_ERR_COUNT};
    if (n <= 1)        return {1'b0, CODE_NONE};
    if (n == END_CNT)  return {1'b1, CODE_END};
    return {1'b1, CODE_ERR_COUNT};
  endfunction

  assign w_cnt_sat   = (r_cnt == CNT_MAX);
  assign w_start_cls = classify_start(r_cnt);
  assign w_end_cls   = classify_end(r_cnt);

`ifdef MAPLE_PATTERN_TIMEOUT_EN
  logic w_any_edge;
  logic w_expired;

  assign w_any_edge = sdcka_posedge | sdcka_negedge | sdckb_posedge | sdckb_negedge;

  maple_stall_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_any_edge),
    .run    (r_state != ST_IDLE),
    .expired(w_expired)
  );

  // Any edge in the expiry cycle counts as activity, so a closing edge always wins
  assign w_timeout = w_expired && !w_any_edge;
`else
  assign w_timeout = 1'b0;
`endif

  // Pattern FSM with registered one-cycle report
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_code  <= CODE_NONE;
      r_count <= '0;
    end else begin
      r_valid <= 1'b0;
      r_code  <= CODE_NONE;
      case (r_state)
        ST_IDLE: begin
          if (!frame_active && sdcka_negedge) begin
            r_state <= ST_START_CNT;
            r_cnt   <= '0;
          end else if (frame_active && sdckb_negedge) begin
            r_state <= ST_END_CNT;
            r_cnt   <= '0;
          end
        end
        ST_START_CNT: begin
          if (sdcka_posedge) begin
            r_state <= ST_IDLE;
            if (w_start_cls[3]) begin
              r_valid <= 1'b1;
              r_code  <= w_start_cls[2:0];
              r_count <= r_cnt;
            end
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b1;
            r_code  <= CODE_ERR_TIMEOUT;
            r_count <= r_cnt;
          end else if (sdckb_negedge && !w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_END_CNT: begin
          if (sdckb_posedge) begin
            r_state <= ST_IDLE;
            if (w_end_cls[3]) begin
              r_valid <= 1'b1;
              r_code  <= w_end_cls[2:0];
              r_count <= r_cnt;
            end
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b1;
            r_code  <= CODE_ERR_TIMEOUT;
            r_count <= r_cnt;
          end else if (sdcka_negedge && !w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pattern_valid = r_valid;
  assign pattern_code  = r_code;
  assign pattern_count = r_count;

endmodule

// File: tb/tb_maple_pattern_decoder.sv
// tb/tb_maple_pattern_decoder.sv - self-checking bench for maple_pattern_decoder
module tb_maple_pattern_decoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a_p = 1'b0, a_n = 1'b0, b_p = 1'b0, b_n = 1'b0;
  logic fa = 1'b0;
  logic use_small = 1'b0;

  logic       m_valid, s_valid;
  logic [2:0] m_code, s_code;
  logic [7:0] m_count;
  logic [2:0] s_count;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int last_count = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int code;
    int count;
    int cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit fa;
    int n;
    bit coinc;
    bit exp_v;
    int code;
    int cnt;
  } vec_t;
  vec_t vecs[14];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maple_pattern_decoder #(
    .CNT_W(8)
`ifdef MAPLE_PATTERN_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .sdcka_posedge(a_p & ~use_small),
    .sdcka_negedge(a_n & ~use_small),
    .sdckb_posedge(b_p & ~use_small),
    .sdckb_negedge(b_n & ~use_small),
    .frame_active (fa),
    .pattern_valid(m_valid),
    .pattern_code (m_code),
    .pattern_count(m_count)
  );

  maple_pattern_decoder #(
    .CNT_W(3)
`ifdef MAPLE_PATTERN_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) u_small (
    .clk          (clk),
    .reset        (reset),
    .sdcka_posedge(a_p & use_small),
    .sdcka_negedge(a_n & use_small),
    .sdckb_posedge(b_p & use_small),
    .sdckb_negedge(b_n & use_small),
    .frame_active (fa),
    .pattern_valid(s_valid),
    .pattern_code (s_code),
    .pattern_count(s_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Scoreboard monitor on the main instance
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_strobe: got code %0d count %0d at cycle %0d, required no strobe",
                   m_code, m_count, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_code", int'(m_code), e.code);
          check("strobe_count", int'(m_count), e.count);
          check("strobe_cycle", cyc, e.cyc);
          last_count = e.count;
        end
      end else begin
        check("idle_code", int'(m_code), 0);
        check("count_hold", int'(m_count), last_count);
      end
    end
  end

  task automatic step(input bit ap, input bit an, input bit bp, input bit bn);
    a_p = ap; a_n = an; b_p = bp; b_n = bn;
    @(posedge clk);
    #1;
    a_p = 1'b0; a_n = 1'b0; b_p = 1'b0; b_n = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  // Opening edge plus n counting edges (with a gap cycle each); leaves FSM counting
  task automatic open_and_count(input bit f, input int n);
    fa = f;
    if (!f) step(0, 1, 0, 0);
    else    step(0, 0, 0, 1);
    for (int i = 0; i < n; i++) begin
      if (!f) step(0, 0, 0, 1);
      else    step(0, 1, 0, 0);
      idle(1);
    end
  endtask

  task automatic close_pattern(input bit f, input bit coinc, input bit exp_v,
                               input int code, input int cnt);
    exp_t e;
    if (!f) step(1, 0, 0, coinc);
    else    step(0, coinc, 1, 0);
    if (exp_v) begin
      e.code = code; e.count = cnt; e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  initial begin
    int last_edge;
    exp_t e;

    vecs[0]  = '{0, 4,  0, 1, 1, 4};
    vecs[1]  = '{0, 6,  0, 1, 2, 6};
    vecs[2]  = '{0, 8,  0, 1, 3, 8};
    vecs[3]  = '{0, 14, 0, 1, 4, 14};
    vecs[4]  = '{0, 5,  0, 1, 6, 5};
    vecs[5]  = '{0, 1,  0, 0, 0, 0};
    vecs[6]  = '{0, 0,  0, 0, 0, 0};
    vecs[7]  = '{0, 2,  0, 1, 6, 2};
    vecs[8]  = '{1, 2,  0, 1, 5, 2};
    vecs[9]  = '{1, 1,  0, 0, 0, 0};
    vecs[10] = '{1, 0,  0, 0, 0, 0};
    vecs[11] = '{1, 3,  0, 1, 6, 3};
    vecs[12] = '{0, 3,  1, 1, 6, 3};
    vecs[13] = '{1, 2,  1, 1, 5, 2};

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset_valid", int'(m_valid), 0);
    check("reset_code", int'(m_code), 0);
    check("reset_count", int'(m_count), 0);
    check("reset_small_valid", int'(s_valid), 0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    for (int i = 0; i < 14; i++) begin
      open_and_count(vecs[i].fa, vecs[i].n);
      close_pattern(vecs[i].fa, vecs[i].coinc, vecs[i].exp_v, vecs[i].code, vecs[i].cnt);
      idle(3);
    end

    // Opening edge in the report cycle is accepted
    open_and_count(0, 4);
    close_pattern(0, 0, 1, 1, 4);
    open_and_count(0, 6);
    close_pattern(0, 0, 1, 2, 6);
    idle(3);

    // frame_active and non-counting edges ignored while counting a start
    fa = 1'b0;
    step(0, 1, 0, 0);
    fa = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      step(0, 1, 0, 0);
    end
    e.code = 1; e.count = 4;
    step(1, 0, 0, 0);
    e.cyc = cyc;
    sb.push_back(e);
    idle(3);

    // Reset mid-pattern aborts without a report
    open_and_count(0, 3);
    reset = 1'b0;
    @(posedge clk);
    #1;
    last_count = 0;
    reset = 1'b1;
    step(1, 0, 0, 0);
    idle(4);

    // Saturation on the narrow instance
    use_small = 1'b1;
    open_and_count(0, 9);
    step(1, 0, 0, 0);
    @(negedge clk);
    check("sat_valid", int'(s_valid), 1);
    check("sat_code", int'(s_code), 6);
    check("sat_count", int'(s_count), 7);
    @(posedge clk);
    #1;
    use_small = 1'b0;
    idle(2);

    // Stall behaviour
    fa = 1'b0;
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    idle(1);
    step(0, 0, 0, 1);
    last_edge = cyc;
`ifdef MAPLE_PATTERN_TIMEOUT_EN
    e.code = 7; e.count = 2; e.cyc = last_edge + 16;
    sb.push_back(e);
    idle(25);
`else
    idle(40);
    e.code = 6; e.count = 2;
    step(1, 0, 0, 0);
    e.cyc = cyc;
    sb.push_back(e);
    idle(3);
`endif

    idle(2);
    check("scoreboard_drained", sb.size(), 0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
